fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 3: width of one write beat, matching the shared FIFO data width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 Parameter MAX_BURST, default 4: maximum accepted beats per grant (1..15).
REQ-004 Parameter OWN_WIDTH, default 2: owner index width, equal to ceil(log2(NUM_REQ)).
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port req, input, NUM_REQ: bit i high means requester i has a beat ready on its data slice.
REQ-008 Port wr_data, input, NUM_REQ*DATA_WIDTH: requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port fifo_full, input, 1: full flag from the shared sync FIFO.
REQ-010 Port gnt, output, NUM_REQ: registered, one-hot or zero, current burst owner.
REQ-011 Port ack, output, NUM_REQ: combinational, beat of requester i is written this cycle.
REQ-012 Port fifo_wr_en, output, 1: combinational write enable to the FIFO.
REQ-013 Port fifo_wr_date, output, DATA_WIDTH: combinational write data to the FIFO.
REQ-014 Port owner, output, OWN_WIDTH: registered binary index of the current owner; 0 when idle.
REQ-015 Port busy, output, 1: registered, high while in state BURST.

Function
REQ-016 The block SHALL implement two states: IDLE (gnt = 0) and BURST (exactly one gnt bit high).
REQ-017 ack[i] SHALL equal gnt[i] & req[i] & !fifo_full; at most one ack bit SHALL be high.
REQ-018 fifo_wr_en SHALL equal the OR of ack; fifo_wr_date SHALL equal the owner's wr_data slice when fifo_wr_en is high and 0 otherwise.
REQ-019 Arbitration SHALL be round-robin: search order starts at index ptr and wraps modulo NUM_REQ; the first index with req high wins.
REQ-020 In IDLE, if any req bit is high, the block SHALL enter BURST next cycle with gnt/owner set to the winner; grant latency from req rise is one cycle, with no beat accepted in the request cycle.
REQ-021 In BURST, each accepted beat (ack high) SHALL increment a beat counter; cycles with fifo_full high SHALL accept no beat, SHALL NOT count, and SHALL hold the grant indefinitely.
REQ-022 The burst SHALL end in the cycle where either (a) req[owner] is low, in which case no beat is accepted, or (b) a beat is accepted and the beat counter reaches MAX_BURST.
REQ-023 At burst end, ptr SHALL become (owner+1) mod NUM_REQ, the beat counter SHALL clear, and arbitration SHALL run in the same cycle using the new ptr.
REQ-024 At burst end, if a winner exists, gnt SHALL switch to it on the next cycle with no idle gap; otherwise the block SHALL enter IDLE.
REQ-025 The ending owner SHALL have lowest priority in the back-to-back arbitration at burst end.
REQ-026 A requester dropping req while it is not the owner SHALL have no effect on the current burst.
REQ-027 The owner's req falling and rising in consecutive cycles SHALL end the burst at the fall; the owner re-competes under round-robin order.
REQ-028 Under continuous requests from all requesters, each requester SHALL be granted within NUM_REQ-1 bursts of its req rising, excluding cycles stalled by fifo_full.

Reset
REQ-029 While rst is high at a clk edge, the block SHALL load state IDLE, ptr 0, beat counter 0, gnt 0, owner 0 and busy 0.
REQ-030 rst asserted mid-burst SHALL abandon the burst with no further beats accepted.
REQ-031 During rst, ack and fifo_wr_en SHALL be 0, because gnt is 0.
REQ-032 The first arbitration after reset SHALL start from index 0.

Verification
REQ-033 Single requester: req=0001 held for 6 cycles, fifo_full=0 -> gnt=0001 from cycle 1; beats accepted in cycles 1-4; gnt returns to 0001 at cycle 5 (the only requester) after the burst ends at 4 beats.
REQ-034 All requesters: req=1111 held, MAX_BURST=4 -> owner sequence 0,1,2,3,0; each burst is 4 writes; no gap cycle between bursts.
REQ-035 Full stall: owner 2 mid-burst with 2 beats done, fifo_full=1 for 5 cycles -> ack=0, fifo_wr_en=0, gnt held; after full drops, exactly 2 more beats are accepted, then the burst ends.
REQ-036 Early drop: owner 1 drops req after 1 beat while req[3]=1 -> burst ends that cycle with no write; gnt=1000 next cycle; ptr=2.
REQ-037 Reset mid-burst: rst=1 during a burst with 3 beats done -> next cycle gnt=0, busy=0, fifo_wr_en=0; after release with req=0110, owner=1 is granted first.
REQ-038 Data routing: for each owner i, fifo_wr_date equals the wr_data[i] slice on every ack cycle and equals 0 on non-write cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges NUM_REQ write streams into one shared sync FIFO.
// A grant lasts until MAX_BURST beats are written or the owner drops req. FIFO-full stalls hold the grant.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int OWN_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_date,
  output logic [OWN_WIDTH-1:0]          owner,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                             state, state_nxt;
  logic [NUM_REQ-1:0]                 gnt_nxt;
  logic [OWN_WIDTH-1:0]               owner_nxt, ptr, ptr_nxt, ptr_arb, owner_inc, win_idx;
  logic [CW-1:0]                      cnt, cnt_nxt;
  logic                               win_found, burst_end, beat;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] beat_data;

  // Per-requester accept and data masking; only the owner's lane can be non-zero.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign ack[i]       = gnt[i] & req[i] & ~fifo_full;
    assign beat_data[i] = ack[i] ? wr_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign beat      = |ack;
  assign owner_inc = (owner == OWN_WIDTH'(NUM_REQ - 1)) ? '0 : owner + OWN_WIDTH'(1);
  assign burst_end = (state == BURST) &&
                     (!req[owner] || (beat && (cnt == CW'(MAX_BURST - 1))));
  // At burst end the search already starts past the old owner, giving it lowest priority.
  assign ptr_arb   = burst_end ? owner_inc : ptr;

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_arb) + k) % NUM_REQ;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = OWN_WIDTH'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BURST;
          gnt_nxt   = NUM_REQ'(1) << win_idx;
          owner_nxt = win_idx;
        end
      end
      BURST: begin
        if (burst_end) begin
          ptr_nxt = owner_inc;
          cnt_nxt = '0;
          if (win_found) begin
            gnt_nxt   = NUM_REQ'(1) << win_idx;
            owner_nxt = win_idx;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            owner_nxt = '0;
          end
        end else if (beat) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy         = (state == BURST);
    fifo_wr_en   = beat;
    fifo_wr_date = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_wr_date = fifo_wr_date | beat_data[i];
  end

endmodule
